// File: rtl/fuzz_run_ctrl_if.sv
// fuzz_run_ctrl_if: host/DUT-side bundle of the fuzz run controller (master = host + DUT, slave = controller)
interface fuzz_run_ctrl_if #(
  parameter int IN_W = 154,
  parameter int OUT_W = 159,
  parameter int CNT_W = 32
);
  logic start;
  logic abort;
  logic [31:0] seed;
  logic [CNT_W-1:0] cycles;
  logic busy;
  logic done;
  logic stim_valid;
  logic [IN_W-1:0] dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [CNT_W-1:0] cyc_count;
  logic [31:0] signature;
  modport master (
    output start, abort, seed, cycles, dut_out,
    input busy, done, stim_valid, dut_in, cyc_count, signature
  );
  modport slave (
    input start, abort, seed, cycles, dut_out,
    output busy, done, stim_valid, dut_in, cyc_count, signature
  );
endinterface

// File: rtl/fuzz_run_ctrl.sv
// fuzz_run_ctrl: seeded xorshift32 stimulus sequencer that compresses DUT responses into a 32-bit MISR
// Ports: clk, rst_n (async active-low); bus.slave carries start/abort/seed/cycles in,
// busy/done/stim_valid/cyc_count/signature out, dut_in to the fuzzed DUT and dut_out back from it.
module fuzz_run_ctrl #(
  parameter int IN_W = 154,
  parameter int OUT_W = 159,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  fuzz_run_ctrl_if.slave bus
);
  localparam logic [31:0] POLY = 32'h04C11DB7;
  typedef enum logic [2:0] {IDLE, SEED, SETTLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] seed_q, prng, sig, fold;
  logic [CNT_W-1:0] n_q, cyc;
  logic [IN_W-1:0] din;
  logic [4:0][31:0] w;
  logic [159:0] vec, opad;
  logic accept, init, load, samp, unused_vec;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  // five chained PRNG words per vector; w0 lands in the MSBs, truncation drops the LSBs of w4
  always_comb begin
    w[0] = xs(prng);
    for (int i = 1; i < 5; i++) w[i] = xs(w[i-1]);
    vec = {w[0], w[1], w[2], w[3], w[4]};
    opad = '0;
    opad[OUT_W-1:0] = bus.dut_out;
    fold = '0;
    for (int i = 0; i < 5; i++) fold = fold ^ opad[32*i +: 32];
  end

  assign unused_vec = ^vec;

  // cyc counts vectors already issued, so RUN cycle k sees cyc == k; the first sample is
  // taken at the end of RUN cycle 2, when the DUT has answered vector 1
  always_comb begin
    state_n = state;
    accept = 1'b0;
    init = 1'b0;
    load = 1'b0;
    samp = 1'b0;
    if (state != IDLE && bus.abort) state_n = IDLE;
    else begin
      case (state)
        IDLE: begin
          accept = bus.start;
          state_n = bus.start ? SEED : IDLE;
        end
        SEED: begin
          init = 1'b1;
          state_n = SETTLE;
        end
        SETTLE: begin
          load = n_q != '0;
          state_n = n_q != '0 ? RUN : DONE;
        end
        RUN: begin
          load = cyc != n_q;
          samp = cyc != CNT_W'(1);
          state_n = cyc != n_q ? RUN : DRAIN;
        end
        DRAIN: begin
          samp = 1'b1;
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= '0;
      n_q <= '0;
      prng <= 32'h1;
      sig <= '0;
      cyc <= '0;
      din <= '0;
    end else begin
      if (accept) begin
        seed_q <= bus.seed;
        n_q <= bus.cycles;
      end
      if (init) begin
        prng <= seed_q == '0 ? 32'h1 : seed_q;
        sig <= '1;
        cyc <= '0;
      end
      if (load) begin
        din <= vec[159 -: IN_W];
        prng <= w[4];
        cyc <= &cyc ? cyc : cyc + CNT_W'(1);
      end
      if (samp) sig <= {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;
    end
  end

  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.stim_valid = state == RUN;
  assign bus.dut_in = din;
  assign bus.cyc_count = cyc;
  assign bus.signature = sig;
endmodule
